shift_cmd_sequencer: RTL and testbench
======================================

Name: shift_cmd_sequencer

Overview:
- Command sequencer that sits directly upstream of the bit-serial variable shifter.
- Accepts shift commands (data, direction, amount) through a valid/ready handshake and queues them in a small FIFO.
- Drives the shifter's load, enable and direction strobes for exactly the commanded number of cycles.
- Captures the shifter output and presents it as a result with its own valid/ready handshake.

Parameters:
- DATA_W, 32, width of shift data and result.
- AMT_W, 5, width of shift amount; amounts 0..2^AMT_W-1.
- CMD_DEPTH, 4, command FIFO depth; power of two, >= 2.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- clr  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_data  in  DATA_W  value to shift.
- cmd_dir  in  1  direction, passed to shifter (0 right, 1 left).
- cmd_amt  in  AMT_W  number of 1-bit shift cycles.
- sh_in  out  DATA_W  parallel load value to shifter.
- sh_load  out  1  one-cycle load strobe (shifter: q <= in).
- sh_en  out  1  shift enable (shifter: q shifts 1 bit per enabled cycle).
- sh_dir  out  1  shift direction.
- sh_q  in  DATA_W  shifter output.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  DATA_W  captured shifter output.
- busy  out  1  state != IDLE or FIFO not empty.

Behaviour:
- Reset (clr=0 at a rising edge):
  - FIFO emptied; state goes to IDLE.
  - cmd_ready=0 while clr=0.
  - sh_in, sh_load, sh_en, sh_dir, res_valid, res_data, busy all 0.
  - A reset mid-operation discards the in-flight command and all queued commands; no partial result is presented.
- Push and pop:
  - cmd_ready = !fifo_full.
  - Push on the edge where cmd_valid && cmd_ready.
  - Push and pop may occur on the same edge.
  - Overflow is impossible; pop occurs only when the FIFO is not empty.
  - FIFO pointers wrap modulo CMD_DEPTH; full/empty are tracked with a count or an extra pointer bit.
- FSM states: IDLE, LOAD, SHIFT, CAPTURE, OUT.
- IDLE:
  - If the FIFO is not empty: pop, latch data/dir/amt into working registers, go to LOAD.
  - Otherwise stay in IDLE.
- LOAD:
  - sh_load=1, sh_in=latched data, sh_dir=latched dir.
  - Load remaining-shift counter with amt.
  - Next state is SHIFT if amt != 0, else CAPTURE.
- SHIFT:
  - sh_en=1, sh_dir held.
  - Counter decrements each cycle; leave to CAPTURE on the cycle the counter reaches 1.
  - sh_en is therefore high for exactly amt consecutive cycles.
- CAPTURE:
  - res_data <= sh_q, res_valid <= 1, go to OUT.
- OUT:
  - Hold res_valid and res_data stable until res_valid && res_ready.
  - On that edge, res_valid <= 0 and go to IDLE.
  - No new pop occurs in the same cycle; the next command is popped in IDLE.
- Output timing:
  - sh_load, sh_en and sh_dir are decoded only from registered state and never overlap.
  - sh_en=0 outside SHIFT; sh_load=0 outside LOAD.
  - sh_in and sh_dir are held from LOAD through CAPTURE.
- Latency:
  - With FIFO empty and state IDLE, a command accepted at edge e0 raises res_valid after edge e0+amt+3.
  - For amt=0 this is 3 cycles.
- Throughput: one command per amt+4 cycles minimum, with res_ready held high.
- Commands keep strict FIFO order; direction and amount are per command.
- Maximum amount 2^AMT_W-1 needs no special case; the counter is AMT_W bits.

Test Plan:
- Right shift by 12: reset, then push data 32'h7105c1a6, dir 0, amt 12, with a behavioural shifter model on sh_*/sh_q and res_ready=1.
  - sh_load high 1 cycle, then sh_en high exactly 12 cycles.
  - res_valid rises 15 cycles after accept; res_data=32'h0007105c.
- Left shift by 5: push 32'h7105c1a6, dir 1, amt 5.
  - sh_en high 5 cycles, sh_dir=1 throughout.
  - res_data=32'h20b834c0, res_valid 8 cycles after accept.
- Zero amount: push 32'hdeadbeef, amt 0.
  - sh_en never asserts.
  - res_valid 3 cycles after accept; res_data=32'hdeadbeef.
- Full FIFO and backpressure: hold res_ready=0, push 6 commands back-to-back.
  - The first is popped; the next 4 fill the FIFO; cmd_ready=0 blocks the 6th until res_ready.
  - Releasing res_ready yields all results in push order.
- Result backpressure: res_ready low for 10 cycles in OUT.
  - res_valid and res_data stay stable; the next command is not popped until the handshake completes.
- Reset mid-SHIFT: pull clr low during cycle 4 of a 12-cycle shift with 2 queued commands.
  - Next cycle: sh_en=0, res_valid=0, busy=0.
  - No stale result appears after clr returns high.

Source files
------------

// File: rtl/shift_cmd_sequencer_if.sv
// Bundle of the command, shifter-control and result signals for the
// shift command sequencer. The sequencer takes the slave view and the
// surrounding environment (command source, shifter, result sink) takes
// the master view.
interface shift_cmd_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int AMT_W  = 5
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_data;
    logic              cmd_dir;
    logic [AMT_W-1:0]  cmd_amt;

    logic [DATA_W-1:0] sh_in;
    logic              sh_load;
    logic              sh_en;
    logic              sh_dir;
    logic [DATA_W-1:0] sh_q;

    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;

    logic              busy;

    modport slave (
        input  cmd_valid, cmd_data, cmd_dir, cmd_amt, sh_q, res_ready,
        output cmd_ready, sh_in, sh_load, sh_en, sh_dir, res_valid, res_data, busy
    );

    modport master (
        output cmd_valid, cmd_data, cmd_dir, cmd_amt, sh_q, res_ready,
        input  cmd_ready, sh_in, sh_load, sh_en, sh_dir, res_valid, res_data, busy
    );
endinterface

// File: rtl/shift_cmd_sequencer.sv
// Command sequencer for a bit-serial variable shifter. Commands (data,
// direction, amount) are queued in a small FIFO, then replayed one at a
// time as a load strobe followed by exactly 'amount' shift-enable cycles.
// The shifter output is captured afterwards and offered as a result with
// its own valid/ready handshake. Strobes are decoded from registered state
// only, so load and enable can never overlap.
module shift_cmd_sequencer #(
    parameter int DATA_W    = 32,
    parameter int AMT_W     = 5,
    parameter int CMD_DEPTH = 4
) (
    input logic                  clk,
    input logic                  clr,
    shift_cmd_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        CAPTURE,
        OUT
    } state_t;

    localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = DATA_W + AMT_W + 1;

    state_t state;
    state_t next_state;

    logic [ENT_W-1:0]  fifo_mem [CMD_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              cmd_ready;
    logic              push;
    logic              pop;
    logic [ENT_W-1:0]  head;

    logic [DATA_W-1:0] work_data;
    logic              work_dir;
    logic [AMT_W-1:0]  work_amt;
    logic [AMT_W-1:0]  shift_cnt;

    logic              res_valid;
    logic [DATA_W-1:0] res_data;

    logic              sh_load;
    logic              sh_en;
    logic              drive_shifter;

    assign fifo_full  = (fifo_count == CNT_W'(CMD_DEPTH));
    assign fifo_empty = (fifo_count == '0);

    // While reset is held the queue refuses commands even though it is empty.
    assign cmd_ready  = clr && !fifo_full;
    assign push       = bus.cmd_valid && cmd_ready;
    assign head       = fifo_mem[rd_ptr];

    // Command queue storage; entries need no reset because occupancy is
    // tracked separately by the count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {bus.cmd_dir, bus.cmd_amt, bus.cmd_data};
        end
    end

    // Queue pointers and occupancy; push and pop may land on the same edge.
    always_ff @(posedge clk) begin
        if (!clr) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + CNT_W'(1);
            end else if (pop && !push) begin
                fifo_count <= fifo_count - CNT_W'(1);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic plus the pop and shifter strobes, all from registered state.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        sh_load    = 1'b0;
        sh_en      = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    next_state = LOAD;
                end
            end
            LOAD: begin
                sh_load    = 1'b1;
                next_state = (work_amt != '0) ? SHIFT : CAPTURE;
            end
            SHIFT: begin
                sh_en = 1'b1;
                if (shift_cnt == AMT_W'(1)) begin
                    next_state = CAPTURE;
                end
            end
            CAPTURE: begin
                next_state = OUT;
            end
            OUT: begin
                if (bus.res_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Working copy of the command being executed and the remaining-shift counter.
    always_ff @(posedge clk) begin
        if (!clr) begin
            work_data <= '0;
            work_dir  <= 1'b0;
            work_amt  <= '0;
            shift_cnt <= '0;
        end else begin
            if (pop) begin
                work_data <= head[DATA_W-1:0];
                work_amt  <= head[DATA_W +: AMT_W];
                work_dir  <= head[ENT_W-1];
            end
            if (state == LOAD) begin
                shift_cnt <= work_amt;
            end else if (state == SHIFT) begin
                shift_cnt <= shift_cnt - AMT_W'(1);
            end
        end
    end

    // Result register: capture the shifter output, hold it until accepted.
    always_ff @(posedge clk) begin
        if (!clr) begin
            res_valid <= 1'b0;
            res_data  <= '0;
        end else if (state == CAPTURE) begin
            res_valid <= 1'b1;
            res_data  <= bus.sh_q;
        end else if (state == OUT && bus.res_ready) begin
            res_valid <= 1'b0;
        end
    end

    // Load value and direction are presented only while a command is in flight.
    assign drive_shifter = (state == LOAD) || (state == SHIFT) || (state == CAPTURE);

    assign bus.cmd_ready = cmd_ready;
    assign bus.sh_in     = drive_shifter ? work_data : '0;
    assign bus.sh_dir    = drive_shifter ? work_dir : 1'b0;
    assign bus.sh_load   = sh_load;
    assign bus.sh_en     = sh_en;
    assign bus.res_valid = res_valid;
    assign bus.res_data  = res_data;
    assign bus.busy      = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Directed testbench for shift_cmd_sequencer. A behavioural shifter model
// closes the loop on sh_*/sh_q; each scenario task drives its own stimulus
// and compares against hand-computed values.
module tb_shift_cmd_sequencer;

    logic clk;
    logic clr;

    int tests_run;
    int tests_failed;

    int          obs_load_cnt;
    int          obs_en_cnt;
    int          obs_first_load;
    int          obs_first_en;
    int          obs_last_en;
    int          obs_valid_k;
    int          obs_dir_bad;
    int          obs_overlap;
    logic [31:0] obs_data;

    shift_cmd_sequencer_if #(.DATA_W(32), .AMT_W(5)) bus ();

    shift_cmd_sequencer #(
        .DATA_W   (32),
        .AMT_W    (5),
        .CMD_DEPTH(4)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
    );

    // Free-running clock, 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural bit-serial shifter driven by the sequencer strobes.
    always @(posedge clk) begin
        if (bus.sh_load) begin
            bus.sh_q <= bus.sh_in;
        end else if (bus.sh_en) begin
            bus.sh_q <= bus.sh_dir ? (bus.sh_q << 1) : (bus.sh_q >> 1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one command and hold it until the edge that accepts it.
    task automatic push_cmd(input logic [31:0] d, input logic dir, input logic [4:0] amt);
        int guard;
        guard         = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = d;
        bus.cmd_dir   = dir;
        bus.cmd_amt   = amt;
        while (!bus.cmd_ready && guard < 200) begin
            tick();
            guard++;
        end
        if (guard >= 200) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL push_timeout: cmd_ready stayed %0b, required 1", bus.cmd_ready);
        end
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    // Watch strobes cycle by cycle after an accept until a result appears.
    task automatic watch_result(input int budget, input logic exp_dir);
        obs_load_cnt   = 0;
        obs_en_cnt     = 0;
        obs_first_load = 0;
        obs_first_en   = 0;
        obs_last_en    = 0;
        obs_valid_k    = 0;
        obs_dir_bad    = 0;
        obs_overlap    = 0;
        obs_data       = '0;
        for (int k = 1; k <= budget; k++) begin
            tick();
            if (bus.sh_load) begin
                obs_load_cnt++;
                if (obs_first_load == 0) obs_first_load = k;
            end
            if (bus.sh_en) begin
                obs_en_cnt++;
                if (obs_first_en == 0) obs_first_en = k;
                obs_last_en = k;
            end
            if ((bus.sh_load || bus.sh_en) && bus.sh_dir !== exp_dir) obs_dir_bad++;
            if (bus.sh_load && bus.sh_en) obs_overlap++;
            if (bus.res_valid) begin
                obs_valid_k = k;
                obs_data    = bus.res_data;
                break;
            end
        end
        if (bus.res_ready) tick();
    endtask

    // Reset state: everything quiet, no command accepted while clr is low.
    task automatic test_reset();
        clr = 1'b0;
        tick();
        tick();
        tests_run++;
        if (bus.cmd_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_cmd_ready: got %0b required 0", bus.cmd_ready);
        end
        tests_run++;
        if ({bus.sh_load, bus.sh_en, bus.sh_dir, bus.res_valid, bus.busy} !== 5'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_strobes: got %b required 00000",
                     {bus.sh_load, bus.sh_en, bus.sh_dir, bus.res_valid, bus.busy});
        end
        tests_run++;
        if (bus.sh_in !== 32'h0 || bus.res_data !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_data: sh_in %h res_data %h required 0", bus.sh_in, bus.res_data);
        end
        clr = 1'b1;
        tick();
        tests_run++;
        if (bus.cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_cmd_ready: got %0b required 1", bus.cmd_ready);
        end
    endtask

    // Right shift by 12 of 7105c1a6.
    task automatic test_right12();
        push_cmd(32'h7105c1a6, 1'b0, 5'd12);
        watch_result(40, 1'b0);
        tests_run++;
        if (obs_valid_k !== 15) begin
            tests_failed++;
            $display("[TB] FAIL r12_latency: got %0d required 15", obs_valid_k);
        end
        tests_run++;
        if (obs_data !== 32'h0007105c) begin
            tests_failed++;
            $display("[TB] FAIL r12_data: got %h required 0007105c", obs_data);
        end
        tests_run++;
        if (obs_load_cnt !== 1 || obs_first_load !== 1) begin
            tests_failed++;
            $display("[TB] FAIL r12_load: count %0d at %0d required 1 at 1", obs_load_cnt, obs_first_load);
        end
        tests_run++;
        if (obs_en_cnt !== 12 || obs_first_en !== 2 || obs_last_en !== 13) begin
            tests_failed++;
            $display("[TB] FAIL r12_enable: count %0d span %0d..%0d required 12 span 2..13",
                     obs_en_cnt, obs_first_en, obs_last_en);
        end
        tests_run++;
        if (obs_dir_bad !== 0 || obs_overlap !== 0) begin
            tests_failed++;
            $display("[TB] FAIL r12_dir_overlap: dir_bad %0d overlap %0d required 0 0", obs_dir_bad, obs_overlap);
        end
    endtask

    // Left shift by 5 of 7105c1a6.
    task automatic test_left5();
        push_cmd(32'h7105c1a6, 1'b1, 5'd5);
        watch_result(30, 1'b1);
        tests_run++;
        if (obs_valid_k !== 8) begin
            tests_failed++;
            $display("[TB] FAIL l5_latency: got %0d required 8", obs_valid_k);
        end
        tests_run++;
        if (obs_data !== 32'h20b834c0) begin
            tests_failed++;
            $display("[TB] FAIL l5_data: got %h required 20b834c0", obs_data);
        end
        tests_run++;
        if (obs_en_cnt !== 5 || obs_dir_bad !== 0) begin
            tests_failed++;
            $display("[TB] FAIL l5_enable_dir: en %0d dir_bad %0d required 5 0", obs_en_cnt, obs_dir_bad);
        end
    endtask

    // Zero amount: load then straight to capture.
    task automatic test_zero();
        push_cmd(32'hdeadbeef, 1'b0, 5'd0);
        watch_result(20, 1'b0);
        tests_run++;
        if (obs_en_cnt !== 0) begin
            tests_failed++;
            $display("[TB] FAIL zero_enable: got %0d cycles required 0", obs_en_cnt);
        end
        tests_run++;
        if (obs_valid_k !== 3) begin
            tests_failed++;
            $display("[TB] FAIL zero_latency: got %0d required 3", obs_valid_k);
        end
        tests_run++;
        if (obs_data !== 32'hdeadbeef) begin
            tests_failed++;
            $display("[TB] FAIL zero_data: got %h required deadbeef", obs_data);
        end
    endtask

    // Fill the queue behind a stalled result, then drain in order.
    task automatic test_full_fifo();
        logic [31:0] cdata [6];
        logic        cdir  [6];
        logic [4:0]  camt  [6];
        logic [31:0] cexp  [6];
        logic [31:0] got   [$];
        int          ready_seen;
        logic        will_push;
        logic        will_take;
        logic [31:0] take_data;

        cdata[0] = 32'h000000f0; cdir[0] = 1'b1; camt[0] = 5'd4;  cexp[0] = 32'h00000f00;
        cdata[1] = 32'h80000000; cdir[1] = 1'b0; camt[1] = 5'd31; cexp[1] = 32'h00000001;
        cdata[2] = 32'h12345678; cdir[2] = 1'b0; camt[2] = 5'd0;  cexp[2] = 32'h12345678;
        cdata[3] = 32'h00000001; cdir[3] = 1'b1; camt[3] = 5'd31; cexp[3] = 32'h80000000;
        cdata[4] = 32'hffff0000; cdir[4] = 1'b0; camt[4] = 5'd8;  cexp[4] = 32'h00ffff00;
        cdata[5] = 32'h0000abcd; cdir[5] = 1'b1; camt[5] = 5'd16; cexp[5] = 32'habcd0000;

        bus.res_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_cmd(cdata[i], cdir[i], camt[i]);

        bus.cmd_valid = 1'b1;
        bus.cmd_data  = cdata[5];
        bus.cmd_dir   = cdir[5];
        bus.cmd_amt   = camt[5];
        ready_seen    = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.cmd_ready) ready_seen++;
            tick();
        end
        tests_run++;
        if (ready_seen !== 0) begin
            tests_failed++;
            $display("[TB] FAIL full_blocks: cmd_ready high %0d cycles required 0", ready_seen);
        end
        tests_run++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== 32'h00000f00) begin
            tests_failed++;
            $display("[TB] FAIL full_first_held: valid %0b data %h required 1 00000f00",
                     bus.res_valid, bus.res_data);
        end

        bus.res_ready = 1'b1;
        for (int c = 0; c < 600 && got.size() < 6; c++) begin
            will_push = bus.cmd_valid && bus.cmd_ready;
            will_take = bus.res_valid && bus.res_ready;
            take_data = bus.res_data;
            tick();
            if (will_push) bus.cmd_valid = 1'b0;
            if (will_take) got.push_back(take_data);
        end
        tests_run++;
        if (got.size() !== 6) begin
            tests_failed++;
            $display("[TB] FAIL full_result_count: got %0d required 6", got.size());
        end
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            tests_run++;
            if (got[i] !== cexp[i]) begin
                tests_failed++;
                $display("[TB] FAIL full_order[%0d]: got %h required %h", i, got[i], cexp[i]);
            end
        end
        bus.cmd_valid = 1'b0;
    endtask

    // Result held under backpressure; queued command waits for the handshake.
    task automatic test_backpressure();
        int          guard;
        int          stable_bad;
        int          load_seen;
        logic [31:0] held;

        bus.res_ready = 1'b0;
        push_cmd(32'h0000000c, 1'b0, 5'd2);
        push_cmd(32'h00000003, 1'b1, 5'd3);
        guard = 0;
        while (!bus.res_valid && guard < 50) begin
            tick();
            guard++;
        end
        held       = bus.res_data;
        stable_bad = 0;
        load_seen  = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!bus.res_valid || bus.res_data !== held) stable_bad++;
            if (bus.sh_load) load_seen++;
        end
        tests_run++;
        if (held !== 32'h00000003) begin
            tests_failed++;
            $display("[TB] FAIL bp_data: got %h required 00000003", held);
        end
        tests_run++;
        if (stable_bad !== 0 || load_seen !== 0) begin
            tests_failed++;
            $display("[TB] FAIL bp_hold: unstable %0d loads %0d required 0 0", stable_bad, load_seen);
        end
        bus.res_ready = 1'b1;
        tick();
        tests_run++;
        if (bus.res_valid !== 1'b0 || bus.busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL bp_release: valid %0b busy %0b required 0 1", bus.res_valid, bus.busy);
        end
        watch_result(20, 1'b1);
        tests_run++;
        if (obs_data !== 32'h00000018 || obs_first_load !== 1) begin
            tests_failed++;
            $display("[TB] FAIL bp_next: data %h load at %0d required 00000018 at 1",
                     obs_data, obs_first_load);
        end
    endtask

    // Reset during the fourth shift cycle with two commands queued.
    task automatic test_reset_mid_shift();
        int stale;

        bus.res_ready = 1'b1;
        push_cmd(32'hffffffff, 1'b0, 5'd12);
        push_cmd(32'h00000055, 1'b1, 5'd1);
        push_cmd(32'h000000aa, 1'b0, 5'd1);
        tick();
        tick();
        tick();
        tests_run++;
        if (bus.sh_en !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL rst_mid_shifting: sh_en %0b required 1", bus.sh_en);
        end
        clr = 1'b0;
        tick();
        tests_run++;
        if ({bus.sh_en, bus.sh_load, bus.res_valid, bus.busy, bus.cmd_ready} !== 5'b0) begin
            tests_failed++;
            $display("[TB] FAIL rst_mid_quiet: en/load/valid/busy/ready %b required 00000",
                     {bus.sh_en, bus.sh_load, bus.res_valid, bus.busy, bus.cmd_ready});
        end
        clr   = 1'b1;
        stale = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.res_valid || bus.sh_load || bus.sh_en) stale++;
        end
        tests_run++;
        if (stale !== 0 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rst_mid_stale: activity %0d busy %0b required 0 0", stale, bus.busy);
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        clr           = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = '0;
        bus.cmd_dir   = 1'b0;
        bus.cmd_amt   = '0;
        bus.res_ready = 1'b1;

        test_reset();
        test_right12();
        test_left5();
        test_zero();
        test_full_fifo();
        test_backpressure();
        test_reset_mid_shift();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
